// File: rtl/axil_arbiter_rr_rd_pkg.sv
// Shared types and helpers for the AXI-Lite round-robin read arbiter.
package axil_arb_pkg;

  localparam int MAX_MASTER = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACKN  = 2'd2
  } arb_state_t;

  // Index width for n entries; never below 1 so n=1 counters still have a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_MASTER-1:0] onehot(input int unsigned idx);
    return MAX_MASTER'(1) << idx;
  endfunction

endpackage

// File: rtl/axil_arbiter_rr_rd_if.sv
// Request/grant and R-channel handshake bundle between masters and the read arbiter.
interface axil_arbiter_rr_rd_if #(
  parameter int NUMBER_MASTER = 2
);
  import axil_arb_pkg::*;
  localparam int IDX_W = idx_width(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0] request_rd;
  logic [NUMBER_MASTER-1:0] grant_rd;
  logic [IDX_W-1:0]         grant_idx;
  logic                     busy;
  logic                     s_axil_rvalid;
  logic [NUMBER_MASTER-1:0] m_axil_rready;
  logic                     timeout_err;

  modport slave (
    input  request_rd, s_axil_rvalid, m_axil_rready,
    output grant_rd, grant_idx, busy, timeout_err
  );

  modport master (
    output request_rd, s_axil_rvalid, m_axil_rready,
    input  grant_rd, grant_idx, busy, timeout_err
  );
endinterface

// File: rtl/axil_rr_pick.sv
// Combinational round-robin pick: first set request after 'last', wrapping.
module axil_rr_pick
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER = 2,
  localparam int IDX_W = idx_width(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] req,
  input  logic [IDX_W-1:0]         last,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);
  localparam int N = NUMBER_MASTER;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] src;
  logic [IDX_W-1:0] off;

  // rot[0] is the master right after 'last', so the lowest set bit wins.
  always_comb begin
    rot = '0;
    src = '0;
    for (int j = 0; j < N; j++) begin
      src    = IDX_W'((int'(last) + 1 + j) % N);
      rot[j] = req[src];
    end
  end

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    hit = |rot;
    idx = IDX_W'((int'(last) + 1 + int'(off)) % N);
  end

endmodule

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin arbiter sharing one AXI-Lite slave read channel among NUMBER_MASTER masters.
// Define AXIL_ARB_TIMEOUT_EN to add the ACKN watchdog and timeout_err pulse.
module axil_arbiter_rr_rd
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER  = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axil_arbiter_rr_rd_if.slave  arb
);
  localparam int N     = NUMBER_MASTER;
  localparam int IDX_W = idx_width(N);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic             rel;

  axil_rr_pick #(.NUMBER_MASTER(N)) u_pick (
    .req  (arb.request_rd),
    .last (last_q),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  // Only the granted master's ready can complete the transaction.
  assign rel = arb.s_axil_rvalid && arb.m_axil_rready[idx_q];

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             expire;
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (|arb.request_rd) state_d = GRANT;
      GRANT: begin
        if (pick_hit) begin
          state_d = ACKN;
          grant_d = N'(onehot(32'(pick_idx)));
          idx_d   = pick_idx;
          last_d  = pick_idx;
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACKN: begin
        if (rel) begin
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        // last_q keeps the stalled master so it drops to lowest priority.
        else if (expire) begin
          grant_d = '0;
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N - 1);
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign arb.grant_rd  = grant_q;
  assign arb.grant_idx = idx_q;
  assign arb.busy      = (state_q != IDLE);

`ifdef AXIL_ARB_TIMEOUT_EN
  assign arb.timeout_err = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo      = (TIMEOUT_CYCLES > 1);
  assign arb.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_arbiter_rr_rd.sv
// Randomized bench for axil_arbiter_rr_rd against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_axil_arbiter_rr_rd;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_arbiter_rr_rd_if #(.NUMBER_MASTER(N)) bus ();

  axil_arbiter_rr_rd #(.NUMBER_MASTER(N), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arb     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int last_m = N - 1;   // model: most recently granted master

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [N-1:0] oh_of(input int g);
    return N'(1) << g;
  endfunction

  // Spec rule: scan masters last+1, last+2, ... with wrap; first requester wins.
  function automatic int ref_pick(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++) begin
      if (r[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  task automatic grant_phase(input logic [N-1:0] req, output int g);
    bus.request_rd = req;
    tick();
    chk("busy_in_grant", 32'(bus.busy), 32'd1);
    chk("grant_wait", 32'(bus.grant_rd), 32'd0);
    tick();
    g = ref_pick(req, last_m);
    last_m = g;
    chk("grant", 32'(bus.grant_rd), 32'(oh_of(g)));
    chk("grant_idx", 32'(bus.grant_idx), 32'(g));
    chk("busy_ackn", 32'(bus.busy), 32'd1);
  endtask

  // rvalid high but only non-granted readies: grant must stay put.
  task automatic hold_phase(input int g, input int cycles);
    for (int h = 0; h < cycles; h++) begin
      bus.s_axil_rvalid = 1'b1;
      bus.m_axil_rready = N'($urandom) & ~oh_of(g);
      bus.request_rd    = N'($urandom);
      tick();
      chk("grant_hold", 32'(bus.grant_rd), 32'(oh_of(g)));
    end
  endtask

  task automatic release_phase(input int g);
    bus.s_axil_rvalid = 1'b1;
    bus.m_axil_rready = N'($urandom) | oh_of(g);
    bus.request_rd    = N'($urandom);
    tick();
    chk("release_grant", 32'(bus.grant_rd), 32'd0);
    chk("release_idx", 32'(bus.grant_idx), 32'(g));
    chk("release_busy", 32'(bus.busy), 32'd0);
    chk("release_tmo", 32'(bus.timeout_err), 32'd0);
    bus.s_axil_rvalid = 1'b0;
    bus.m_axil_rready = '0;
  endtask

  task automatic txn(input logic [N-1:0] req, input int hold);
    int g;
    grant_phase(req, g);
    hold_phase(g, hold);
    release_phase(g);
  endtask

  logic [N-1:0] dir_req [9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b0100, 4'b0011, 4'b0010, 4'b0001};

  initial begin
    int g;
    bus.request_rd    = '0;
    bus.s_axil_rvalid = 1'b0;
    bus.m_axil_rready = '0;
    #1;
    chk("rst_grant", 32'(bus.grant_rd), 32'd0);
    chk("rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Rotation with all requesting, wrap from last=2, then single requesters.
    foreach (dir_req[i]) txn(dir_req[i], 1);

    // Request dropped before GRANT evaluates: no grant, pointer untouched.
    bus.request_rd = N'($urandom_range(1, 15));
    tick();
    chk("pulse_busy", 32'(bus.busy), 32'd1);
    bus.request_rd = '0;
    tick();
    chk("pulse_grant", 32'(bus.grant_rd), 32'd0);
    chk("pulse_busy_idle", 32'(bus.busy), 32'd0);
    txn(4'b1111, 0);

    for (int t = 0; t < 40; t++) txn(N'($urandom_range(1, 15)), $urandom_range(0, 3));

    // Stalled slave.
    grant_phase(N'($urandom_range(1, 15)), g);
    bus.request_rd    = '0;
    bus.s_axil_rvalid = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
    for (int c = 0; c < TMO - 1; c++) begin
      tick();
      chk("tmo_hold", 32'(bus.grant_rd), 32'(oh_of(g)));
      chk("tmo_quiet", 32'(bus.timeout_err), 32'd0);
    end
    tick();
    chk("tmo_grant", 32'(bus.grant_rd), 32'd0);
    chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("tmo_pulse_end", 32'(bus.timeout_err), 32'd0);
`else
    for (int c = 0; c < 3 * TMO; c++) begin
      tick();
      chk("stall_hold", 32'(bus.grant_rd), 32'(oh_of(g)));
      chk("stall_tmo", 32'(bus.timeout_err), 32'd0);
    end
    release_phase(g);
`endif
    txn(4'b1111, 1);

    // Async reset in ACKN drops the grant without a clock edge.
    grant_phase(N'($urandom_range(1, 15)), g);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant_rd), 32'd0);
    chk("arst_idx", 32'(bus.grant_idx), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    bus.request_rd = '0;
    last_m = N - 1;
    #1 aresetn = 1'b1;
    txn(4'b1111, 1);
    txn(4'b1010, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
